// File: rtl/run_ctrl_pkg.sv
// run_ctrl_pkg: state encoding and sizing helpers shared by the run controller files.
package run_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    LOAD   = 3'd2,
    LAUNCH = 3'd3,
    RUN    = 3'd4,
    DUMP   = 3'd5,
    FIN    = 3'd6
  } state_t;

  localparam int unsigned DEF_ADDR_W = 8;
  localparam int unsigned DEPTH      = 32'd1 << DEF_ADDR_W;

  function automatic int unsigned depth_of(input int unsigned addr_w);
    return 32'd1 << addr_w;
  endfunction

endpackage

// File: rtl/run_ctrl_wdog.sv
// run_ctrl_wdog: saturating RUN-cycle counter with a watchdog limit compare.
module run_ctrl_wdog #(
  parameter int unsigned CNT_W      = 32,
  parameter int unsigned MAX_CYCLES = 100000
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clr,
  input  logic             i_en,
  output logic [CNT_W-1:0] o_count,
  output logic             o_expired
);

  // A zero limit disables the compare entirely, so the limit value itself is irrelevant then.
  localparam logic [CNT_W-1:0] L_LIMIT =
    (MAX_CYCLES == 32'd0) ? {CNT_W{1'b0}} : CNT_W'(MAX_CYCLES - 32'd1);

  logic [CNT_W-1:0] r_count;

  // Count enabled cycles, holding at all-ones instead of wrapping.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_count <= {CNT_W{1'b0}};
    end else if (i_clr) begin
      r_count <= {CNT_W{1'b0}};
    end else if (i_en && (r_count != {CNT_W{1'b1}})) begin
      r_count <= r_count + CNT_W'(1'b1);
    end else begin
      r_count <= r_count;
    end
  end

  assign o_count   = r_count;
  assign o_expired = (MAX_CYCLES != 32'd0) && (r_count == L_LIMIT);

endmodule

// File: rtl/run_ctrl.sv
// run_ctrl: memory clear, preload, launch and halt-wait sequencer for the single-cycle CPU.
// Define RUN_CTRL_DUMP_EN to add a post-run dump of the result window.
module run_ctrl
  import run_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned CNT_W      = 32,
  parameter int unsigned MAX_CYCLES = 100000
`ifdef RUN_CTRL_DUMP_EN
  ,
  parameter int unsigned DUMP_BASE  = 8,
  parameter int unsigned DUMP_LEN   = 4
`endif
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              go,
  input  logic              pl_valid,
  output logic              pl_ready,
  input  logic [ADDR_W-1:0] pl_addr,
  input  logic [DATA_W-1:0] pl_data,
  input  logic              pl_last,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              core_start,
  input  logic              core_halt,
  output logic              busy,
  output logic              done,
  output logic              timeout,
  output logic [CNT_W-1:0]  cycles
`ifdef RUN_CTRL_DUMP_EN
  ,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              dump_valid,
  output logic [DATA_W-1:0] dump_data,
  input  logic              dump_ready
`endif
);

  localparam logic [ADDR_W-1:0] L_LAST_ADDR = ADDR_W'(depth_of(ADDR_W) - 32'd1);

  state_t           r_state;
  state_t           w_state_nxt;
  state_t           w_exit_state;
  logic [ADDR_W-1:0] r_clr_addr;
  logic             r_done;
  logic             r_timeout;
  logic             w_go_acc;
  logic             w_run;
  logic             w_run_exit;
  logic             w_expired;
  logic [CNT_W-1:0] w_count;

  assign w_go_acc   = go && ((r_state == IDLE) || (r_state == FIN));
  assign w_run      = (r_state == RUN);
  assign w_run_exit = w_run && (core_halt || w_expired);

`ifdef RUN_CTRL_DUMP_EN
  localparam logic [ADDR_W-1:0] L_DUMP_BASE = ADDR_W'(DUMP_BASE);
  localparam logic [ADDR_W-1:0] L_DUMP_LAST = ADDR_W'(DUMP_LEN - 32'd1);

  logic [ADDR_W-1:0] r_dump_k;
  logic              w_dump_last;

  assign w_exit_state = DUMP;
  assign w_dump_last  = (r_state == DUMP) && dump_ready && (r_dump_k == L_DUMP_LAST);
  assign dump_valid   = (r_state == DUMP);
  assign dump_data    = (r_state == DUMP) ? mem_rdata : {DATA_W{1'b0}};

  // Result-window word index, advanced only by an accepted dump word.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_dump_k <= {ADDR_W{1'b0}};
    end else if (r_state != DUMP) begin
      r_dump_k <= {ADDR_W{1'b0}};
    end else if (dump_ready) begin
      r_dump_k <= r_dump_k + ADDR_W'(1'b1);
    end else begin
      r_dump_k <= r_dump_k;
    end
  end
`else
  assign w_exit_state = FIN;
`endif

  run_ctrl_wdog #(
    .CNT_W      (CNT_W),
    .MAX_CYCLES (MAX_CYCLES)
  ) u_wdog (
    .i_clk     (CLK),
    .i_rst_n   (RST_N),
    .i_clr     (w_go_acc),
    .i_en      (w_run),
    .o_count   (w_count),
    .o_expired (w_expired)
  );

  // Sequence next-state selection.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE, FIN: begin
        if (go) w_state_nxt = CLEAR;
        else    w_state_nxt = r_state;
      end
      CLEAR: begin
        if (r_clr_addr == L_LAST_ADDR) w_state_nxt = LOAD;
        else                           w_state_nxt = CLEAR;
      end
      LOAD: begin
        if (pl_valid && pl_last) w_state_nxt = LAUNCH;
        else                     w_state_nxt = LOAD;
      end
      LAUNCH: w_state_nxt = RUN;
      RUN: begin
        if (w_run_exit) w_state_nxt = w_exit_state;
        else            w_state_nxt = RUN;
      end
`ifdef RUN_CTRL_DUMP_EN
      DUMP: begin
        if (w_dump_last) w_state_nxt = FIN;
        else             w_state_nxt = DUMP;
      end
`endif
      default: w_state_nxt = IDLE;
    endcase
  end

  // Memory port and preload handshake; held inactive while reset is asserted so an abort writes nothing.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = {ADDR_W{1'b0}};
    mem_wdata = {DATA_W{1'b0}};
    pl_ready  = 1'b0;
    case (r_state)
      CLEAR: begin
        mem_we   = 1'b1;
        mem_addr = r_clr_addr;
      end
      LOAD: begin
        pl_ready = 1'b1;
        if (pl_valid) begin
          mem_we    = 1'b1;
          mem_addr  = pl_addr;
          mem_wdata = pl_data;
        end else begin
          mem_we    = 1'b0;
        end
      end
`ifdef RUN_CTRL_DUMP_EN
      DUMP: mem_addr = L_DUMP_BASE + r_dump_k;
`endif
      default: mem_we = 1'b0;
    endcase
    if (!RST_N) begin
      mem_we   = 1'b0;
      pl_ready = 1'b0;
    end else begin
      pl_ready = pl_ready;
    end
  end

  // State, clear address and sticky completion flags.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_state    <= IDLE;
      r_clr_addr <= {ADDR_W{1'b0}};
      r_done     <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == CLEAR) r_clr_addr <= r_clr_addr + ADDR_W'(1'b1);
      else                  r_clr_addr <= {ADDR_W{1'b0}};
      // Halt takes priority when it coincides with the watchdog limit.
      if (w_go_acc) begin
        r_done    <= 1'b0;
        r_timeout <= 1'b0;
      end else if (w_run && core_halt) begin
        r_done    <= 1'b1;
      end else if (w_run_exit) begin
        r_timeout <= 1'b1;
      end else begin
        r_done    <= r_done;
      end
    end
  end

  assign core_start = (r_state != RUN);
  assign busy       = !((r_state == IDLE) || (r_state == FIN));
  assign done       = r_done;
  assign timeout    = r_timeout;
  assign cycles     = w_count;

endmodule

// File: tb/tb_run_ctrl.sv
// tb_run_ctrl: randomized self-checking bench for run_ctrl with a behavioural memory and CPU model.
// Define RUN_CTRL_DUMP_EN to also exercise the result-window dump.
module tb_run_ctrl;

  localparam int AW    = 8;
  localparam int DW    = 8;
  localparam int CW    = 32;
  localparam int MAXC  = 50;
  localparam int DEPTH = 1 << AW;
  localparam int DBASE = 8;
  localparam int DLEN  = 4;

  logic          CLK = 1'b0;
  logic          RST_N = 1'b0;
  logic          go = 1'b0;
  logic          pl_valid = 1'b0;
  logic          pl_last = 1'b0;
  logic          core_halt = 1'b0;
  logic [AW-1:0] pl_addr = '0;
  logic [DW-1:0] pl_data = '0;
  logic          pl_ready, mem_we, core_start, busy, done, timeout;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [CW-1:0] cycles;
`ifdef RUN_CTRL_DUMP_EN
  logic [DW-1:0] mem_rdata;
  logic          dump_valid;
  logic          dump_ready = 1'b0;
  logic [DW-1:0] dump_data;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0] mem_env [DEPTH];
  logic [DW-1:0] ref_mem [DEPTH];
  logic [AW-1:0] q_addr [$];
  logic [DW-1:0] q_data [$];

  always #5 CLK = ~CLK;

  // Data memory attached to the controller's write port.
  always @(posedge CLK) begin
    if (mem_we === 1'b1) mem_env[mem_addr] <= mem_wdata;
  end

`ifdef RUN_CTRL_DUMP_EN
  assign mem_rdata = mem_env[mem_addr];
`endif

  run_ctrl #(
    .ADDR_W(AW), .DATA_W(DW), .CNT_W(CW), .MAX_CYCLES(MAXC)
  ) dut (
    .CLK(CLK), .RST_N(RST_N), .go(go),
    .pl_valid(pl_valid), .pl_ready(pl_ready), .pl_addr(pl_addr), .pl_data(pl_data), .pl_last(pl_last),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .core_start(core_start), .core_halt(core_halt),
    .busy(busy), .done(done), .timeout(timeout), .cycles(cycles)
`ifdef RUN_CTRL_DUMP_EN
    , .mem_rdata(mem_rdata), .dump_valid(dump_valid), .dump_data(dump_data), .dump_ready(dump_ready)
`endif
  );

  task automatic make_random_preload(input int n);
    q_addr.delete();
    q_data.delete();
    for (int i = 0; i < n; i++) begin
      q_addr.push_back(AW'($urandom));
      q_data.push_back(DW'($urandom));
    end
  endtask

  // go, then checks every clear cycle, every preload cycle, the launch cycle and the final memory image.
  task automatic drive_setup(input int gap_pct);
    for (int a = 0; a < DEPTH; a++) ref_mem[a] = '0;
    @(negedge CLK);
    go = 1'b1;
    #1;
    n_checks++;
    if (busy !== 1'b0 || core_start !== 1'b1) begin
      n_fail++;
      $display("FAIL setup_idle: busy=%b core_start=%b, required busy=0 core_start=1", busy, core_start);
    end
    @(negedge CLK);
    for (int i = 0; i < DEPTH; i++) begin
      go = 1'($urandom);
      pl_valid = 1'($urandom);
      pl_last = 1'($urandom);
      core_halt = 1'($urandom);
      pl_data = DW'($urandom);
      #1;
      n_checks++;
      if (mem_we !== 1'b1 || mem_addr !== AW'(i) || mem_wdata !== '0 || pl_ready !== 1'b0 ||
          core_start !== 1'b1 || busy !== 1'b1 || done !== 1'b0 || timeout !== 1'b0 || cycles !== '0) begin
        n_fail++;
        $display("FAIL clear[%0d]: we=%b addr=%0d wdata=%h rdy=%b start=%b busy=%b done=%b to=%b cyc=%0d, required we=1 addr=%0d wdata=00 rdy=0 start=1 busy=1 done=0 to=0 cyc=0",
                 i, mem_we, mem_addr, mem_wdata, pl_ready, core_start, busy, done, timeout, cycles, i);
      end
      @(negedge CLK);
    end
    go = 1'b0;
    for (int w = 0; w < q_addr.size(); w++) begin
      for (int g = 0; g < 3 && $urandom_range(99, 0) < gap_pct; g++) begin
        pl_valid = 1'b0;
        pl_last = 1'($urandom);
        pl_addr = AW'($urandom);
        core_halt = 1'($urandom);
        #1;
        n_checks++;
        if (pl_ready !== 1'b1 || mem_we !== 1'b0 || core_start !== 1'b1) begin
          n_fail++;
          $display("FAIL load_gap: rdy=%b we=%b start=%b, required rdy=1 we=0 start=1", pl_ready, mem_we, core_start);
        end
        @(negedge CLK);
      end
      pl_valid = 1'b1;
      pl_addr = q_addr[w];
      pl_data = q_data[w];
      pl_last = (w == q_addr.size() - 1);
      #1;
      n_checks++;
      if (pl_ready !== 1'b1 || mem_we !== 1'b1 || mem_addr !== q_addr[w] || mem_wdata !== q_data[w] || core_start !== 1'b1) begin
        n_fail++;
        $display("FAIL load_word[%0d]: rdy=%b we=%b addr=%0d wdata=%h start=%b, required rdy=1 we=1 addr=%0d wdata=%h start=1",
                 w, pl_ready, mem_we, mem_addr, mem_wdata, core_start, q_addr[w], q_data[w]);
      end
      ref_mem[q_addr[w]] = q_data[w];
      @(negedge CLK);
    end
    pl_valid = 1'b1;
    pl_last = 1'b1;
    core_halt = 1'b0;
    #1;
    n_checks++;
    if (core_start !== 1'b1 || mem_we !== 1'b0 || pl_ready !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL launch: start=%b we=%b rdy=%b busy=%b, required start=1 we=0 rdy=0 busy=1", core_start, mem_we, pl_ready, busy);
    end
    @(negedge CLK);
    pl_valid = 1'b0;
    pl_last = 1'b0;
    #1;
    n_checks++;
    if (core_start !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL run_entry: start=%b busy=%b, required start=0 busy=1", core_start, busy);
    end
    for (int a = 0; a < DEPTH; a++) begin
      n_checks++;
      if (mem_env[a] !== ref_mem[a]) begin
        n_fail++;
        $display("FAIL mem_image[%0d]: got %h, required %h", a, mem_env[a], ref_mem[a]);
      end
    end
  endtask

  // CPU model: halts on RUN cycle halt_at (0 = never); then the end-of-run state is checked.
  task automatic run_cpu(input int halt_at, input bit poke, input int stall0);
    int  n_run;
    int  exp_cyc;
    int  st;
    bit  exp_done;
    exp_done = (halt_at >= 1) && (halt_at <= MAXC);
    exp_cyc = exp_done ? halt_at : MAXC;
    n_run = 0;
    while (core_start === 1'b0 && n_run < 4 * MAXC) begin
      n_run++;
      core_halt = (n_run == halt_at);
      if (poke) begin
        go = 1'($urandom);
        pl_valid = 1'($urandom);
        pl_addr = AW'($urandom);
        pl_last = 1'($urandom);
        #1;
        n_checks++;
        if (pl_ready !== 1'b0 || mem_we !== 1'b0 || busy !== 1'b1) begin
          n_fail++;
          $display("FAIL run_ignore: rdy=%b we=%b busy=%b, required rdy=0 we=0 busy=1", pl_ready, mem_we, busy);
        end
      end
      @(negedge CLK);
    end
    core_halt = 1'b0;
    go = 1'b0;
    pl_valid = 1'b0;
    pl_last = 1'b0;
`ifdef RUN_CTRL_DUMP_EN
    for (int k = 0; k < DLEN; k++) begin
      st = (k == 0) ? stall0 : $urandom_range(1, 0);
      for (int s = 0; s <= st; s++) begin
        dump_ready = (s == st);
        #1;
        n_checks++;
        if (dump_valid !== 1'b1 || dump_data !== ref_mem[DBASE + k] || busy !== 1'b1 || core_start !== 1'b1) begin
          n_fail++;
          $display("FAIL dump[%0d]: valid=%b data=%h busy=%b start=%b, required valid=1 data=%h busy=1 start=1",
                   k, dump_valid, dump_data, busy, core_start, ref_mem[DBASE + k]);
        end
        @(negedge CLK);
      end
    end
    dump_ready = 1'b0;
`else
    st = stall0;
`endif
    #1;
    n_checks++;
    if (n_run != exp_cyc || cycles !== CW'(exp_cyc)) begin
      n_fail++;
      $display("FAIL run_length: run cycles=%0d count=%0d, required %0d", n_run, cycles, exp_cyc);
    end
    n_checks++;
    if (done !== exp_done || timeout !== !exp_done || busy !== 1'b0 || core_start !== 1'b1) begin
      n_fail++;
      $display("FAIL run_end: done=%b timeout=%b busy=%b start=%b, required done=%b timeout=%b busy=0 start=1",
               done, timeout, busy, core_start, exp_done, !exp_done);
    end
    core_halt = 1'b1;
    repeat (3) @(negedge CLK);
    core_halt = 1'b0;
    #1;
    n_checks++;
    if (cycles !== CW'(exp_cyc) || done !== exp_done || timeout !== !exp_done || busy !== 1'b0 || core_start !== 1'b1) begin
      n_fail++;
      $display("FAIL fin_hold: cycles=%0d done=%b timeout=%b busy=%b start=%b, required cycles=%0d done=%b timeout=%b busy=0 start=1",
               cycles, done, timeout, busy, core_start, exp_cyc, exp_done, !exp_done);
    end
  endtask

  task automatic test_reset();
    RST_N = 1'b0;
    repeat (2) @(negedge CLK);
    #1;
    n_checks++;
    if (mem_we !== 1'b0 || mem_addr !== '0 || mem_wdata !== '0 || pl_ready !== 1'b0 || core_start !== 1'b1 ||
        busy !== 1'b0 || done !== 1'b0 || timeout !== 1'b0 || cycles !== '0) begin
      n_fail++;
      $display("FAIL reset_values: we=%b addr=%0d wdata=%h rdy=%b start=%b busy=%b done=%b to=%b cyc=%0d, required all 0 except start=1",
               mem_we, mem_addr, mem_wdata, pl_ready, core_start, busy, done, timeout, cycles);
    end
    RST_N = 1'b1;
    @(negedge CLK);
    #1;
    n_checks++;
    if (busy !== 1'b0 || core_start !== 1'b1 || mem_we !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: busy=%b start=%b we=%b, required busy=0 start=1 we=0", busy, core_start, mem_we);
    end
  endtask

  task automatic test_clear_preload();
    q_addr = '{8'd9, 8'd8, 8'd10, 8'd11};
    q_data = '{8'h70, 8'h00, 8'h00, 8'h00};
    drive_setup(0);
  endtask

  task automatic test_halt();
    run_cpu(37, 1'b0, 3);
  endtask

  task automatic test_watchdog();
    make_random_preload(2);
    drive_setup(0);
    run_cpu(0, 1'b0, 0);
    make_random_preload(3);
    drive_setup(0);
    run_cpu(MAXC, 1'b0, 1);
    make_random_preload(1);
    drive_setup(0);
    run_cpu(MAXC + 1, 1'b0, 0);
  endtask

  task automatic test_backpressure();
    make_random_preload(6);
    q_addr[4] = q_addr[1];
    drive_setup(50);
    run_cpu($urandom_range(45, 1), 1'b1, 2);
  endtask

  task automatic test_reset_mid_load();
    make_random_preload(4);
    @(negedge CLK);
    go = 1'b1;
    @(negedge CLK);
    go = 1'b0;
    repeat (DEPTH) @(negedge CLK);
    for (int w = 0; w < 2; w++) begin
      pl_valid = 1'b1;
      pl_addr = q_addr[w];
      pl_data = q_data[w];
      pl_last = 1'b0;
      @(negedge CLK);
    end
    RST_N = 1'b0;
    @(negedge CLK);
    RST_N = 1'b1;
    #1;
    n_checks++;
    if (mem_we !== 1'b0 || core_start !== 1'b1 || busy !== 1'b0 || pl_ready !== 1'b0 ||
        done !== 1'b0 || timeout !== 1'b0 || cycles !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_load: we=%b start=%b busy=%b rdy=%b done=%b to=%b cyc=%0d, required we=0 start=1 busy=0 rdy=0 done=0 to=0 cyc=0",
               mem_we, core_start, busy, pl_ready, done, timeout, cycles);
    end
    pl_valid = 1'b0;
    make_random_preload(3);
    drive_setup(20);
    run_cpu($urandom_range(60, 1), 1'b0, 0);
  endtask

  task automatic test_random_runs();
    for (int r = 0; r < 4; r++) begin
      make_random_preload($urandom_range(6, 1));
      drive_setup(30);
      run_cpu($urandom_range(60, 1), 1'($urandom), $urandom_range(2, 0));
    end
  endtask

  initial begin
    test_reset();
    test_clear_preload();
    test_halt();
    test_watchdog();
    test_backpressure();
    test_reset_mid_load();
    test_random_runs();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation time limit reached, required completion");
    $fatal(1, "time limit");
  end

endmodule
